// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the combinational ALU.
// Holds accumulator and flags, chains carry across commands.
module alu_cmd_sequencer #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_opcode,
    input  logic [BUS_WIDTH-1:0] cmd_operand,
    output logic [3:0]           alu_opcode,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic                 alu_carry_in,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic [4:0]           alu_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BUS_WIDTH-1:0] rsp_result,
    output logic [4:0]           rsp_flags,
    output logic [BUS_WIDTH-1:0] acc
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } state_t;

    localparam logic [4:0] FLAGS_RST = 5'b00100;

    state_t               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [BUS_WIDTH-1:0] opnd_q, opnd_d;
    logic [BUS_WIDTH-1:0] acc_q, acc_d;
    logic [4:0]           flags_q, flags_d;
    logic [3:0]           alu_op_q, alu_op_d;
    logic [BUS_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [BUS_WIDTH-1:0] res_q, res_d;
    logic [4:0]           rflags_q, rflags_d;
    logic [4:0]           load_flags;

    // Flags a LOAD reports: parity and zero of the loaded value only.
    assign load_flags = {1'b0, ^opnd_q, (opnd_q == '0), 2'b00};

    assign cmd_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign alu_opcode   = alu_op_q;
    assign alu_a        = acc_q;
    assign alu_b        = alu_b_q;
    assign alu_carry_in = flags_q[0];
    assign rsp_result   = res_q;
    assign rsp_flags    = rflags_q;
    assign acc          = acc_q;

    // Next-state and datapath updates for the command FSM.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        flags_d  = flags_q;
        alu_op_d = alu_op_q;
        alu_b_d  = alu_b_q;
        res_d    = res_q;
        rflags_d = rflags_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_opcode;
                    opnd_d = cmd_operand;
                    if (cmd_opcode == 4'd0) begin
                        state_d = CAPT;
                    end else begin
                        // ALU inputs only move for real ALU commands.
                        alu_op_d = cmd_opcode;
                        alu_b_d  = cmd_operand;
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                state_d = CAPT;
            end
            CAPT: begin
                if (op_q == 4'd0) begin
                    acc_d    = opnd_q;
                    res_d    = opnd_q;
                    rflags_d = load_flags;
                    flags_d  = load_flags;
                end else begin
                    res_d    = alu_y;
                    rflags_d = alu_flags;
                    flags_d  = alu_flags;
                    // Invalid opcodes leave the accumulator intact.
                    if (!alu_flags[4]) begin
                        acc_d = alu_y;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            flags_q  <= FLAGS_RST;
            alu_op_q <= '0;
            alu_b_q  <= '0;
            res_q    <= '0;
            rflags_q <= FLAGS_RST;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            flags_q  <= flags_d;
            alu_op_q <= alu_op_d;
            alu_b_q  <= alu_b_d;
            res_q    <= res_d;
            rflags_q <= rflags_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural ALU attached.
// Expected responses are queued at issue and compared on handshake.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode;
    logic [7:0] cmd_operand;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_carry_in;
    logic [7:0] alu_y;
    logic [4:0] alu_flags;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [4:0] rsp_flags;
    logic [7:0] acc;

    int n_assert;
    int n_fail;
    logic [12:0] sb[$];

    alu_cmd_sequencer #(.BUS_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_operand  (cmd_operand),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_carry_in (alu_carry_in),
        .alu_y        (alu_y),
        .alu_flags    (alu_flags),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .acc          (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: flags = {invalid, parity, zero, borrow, carry}.
    logic [8:0] s;
    logic       inv, bo, co;
    always_comb begin
        s     = '0;
        alu_y = '0;
        inv   = 1'b0;
        bo    = 1'b0;
        co    = 1'b0;
        case (alu_opcode)
            4'd1: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y = s[7:0];
                co = s[8];
            end
            4'd2: begin
                s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
                alu_y = s[7:0];
                co = s[8];
            end
            4'd3: begin
                alu_y = alu_a - alu_b;
                bo = (alu_a < alu_b);
            end
            4'd4: begin
                s = {1'b0, alu_a} + 9'd1;
                alu_y = s[7:0];
                co = s[8];
            end
            4'd5: begin
                alu_y = alu_a - 8'd1;
                bo = (alu_a == 8'd0);
            end
            4'd6: alu_y = alu_a & alu_b;
            4'd7: alu_y = ~alu_a;
            4'd8: alu_y = {alu_a[6:0], alu_a[7]};
            4'd9: alu_y = {alu_a[0], alu_a[7:1]};
            default: inv = 1'b1;
        endcase
        alu_flags = {inv, ^alu_y, (alu_y == 8'd0), bo, co};
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop_cmp();
        logic [12:0] e;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("rsp_result", rsp_result, e[12:5]);
            check("rsp_flags", rsp_flags, e[4:0]);
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
    endtask

    task automatic do_cmd(input logic [3:0] op,
                          input logic [7:0] opnd,
                          input logic [7:0] er,
                          input logic [4:0] ef,
                          input int cin_exp);
        int lat;
        sb.push_back({er, ef});
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_operand = opnd;
        lat = 0;
        while (!cmd_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("busy_after_accept", cmd_ready, 0);
        if (op != 4'd0) begin
            check("exec_opcode", alu_opcode, op);
            check("exec_b", alu_b, opnd);
        end
        if (cin_exp >= 0) begin
            check("exec_cin", alu_carry_in, cin_exp[0]);
        end
        wait_rsp(lat);
        check("latency", lat, (op == 4'd0) ? 1 : 2);
        pop_cmp();
        handshake();
    endtask

    int lat;

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_opcode  = '0;
        cmd_operand = '0;
        rsp_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_acc", acc, 0);
        check("rst_rsp_flags", rsp_flags, 5'b00100);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_alu_b", alu_b, 0);
        @(negedge clk);
        reset = 1'b0;

        // Early rsp_ready must not create a response.
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("early_ready", rsp_valid, 0);
        rsp_ready = 1'b0;

        do_cmd(4'd0, 8'hF0, 8'hF0, 5'b00000, -1);
        check("acc_load_f0", acc, 8'hF0);
        do_cmd(4'd1, 8'h20, 8'h10, 5'b01001, 0);
        check("acc_add", acc, 8'h10);
        check("carry_stored", alu_carry_in, 1);
        do_cmd(4'd2, 8'h01, 8'h12, 5'b00000, 1);
        check("acc_adc", acc, 8'h12);

        do_cmd(4'd0, 8'h05, 8'h05, 5'b00000, -1);
        do_cmd(4'd3, 8'h05, 8'h00, 5'b00100, 0);
        do_cmd(4'd5, 8'h00, 8'hFF, 5'b00010, 0);
        check("acc_dec", acc, 8'hFF);

        do_cmd(4'd0, 8'h3C, 8'h3C, 5'b00000, -1);
        do_cmd(4'd12, 8'h55, 8'h00, 5'b10100, 0);
        check("acc_invalid", acc, 8'h3C);
        check("cin_invalid", alu_carry_in, 0);
        do_cmd(4'd2, 8'h01, 8'h3D, 5'b01000, 0);

        do_cmd(4'd0, 8'h81, 8'h81, 5'b00000, -1);
        do_cmd(4'd8, 8'h00, 8'h03, 5'b00000, 0);

        // Backpressure with a blocked command waiting behind it.
        sb.push_back({8'h04, 5'b01000});
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_opcode  = 4'd1;
        cmd_operand = 8'h01;
        @(posedge clk);
        #1;
        cmd_opcode  = 4'd0;
        cmd_operand = 8'h77;
        wait_rsp(lat);
        check("bp_latency", lat, 2);
        pop_cmp();
        sb.push_back({8'h77, 5'b00000});
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, 8'h04);
            check("bp_flags", rsp_flags, 5'b01000);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_acc", acc, 8'h04);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_valid_drop", rsp_valid, 0);
        check("bp_ready_back", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("bp_accept", cmd_ready, 0);
        wait_rsp(lat);
        check("bp_load_latency", lat, 1);
        pop_cmp();
        check("bp_acc_load", acc, 8'h77);
        handshake();

        // Reset while the ALU command sits in EXEC.
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_opcode  = 4'd1;
        cmd_operand = 8'h11;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("mid_exec_op", alu_opcode, 4'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_cmd_ready", cmd_ready, 1);
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_acc", acc, 0);
        check("mr_alu_opcode", alu_opcode, 0);
        check("mr_alu_b", alu_b, 0);
        check("mr_rsp_flags", rsp_flags, 5'b00100);
        check("mr_rsp_result", rsp_result, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("mr_no_rsp", rsp_valid, 0);
        end
        do_cmd(4'd0, 8'h00, 8'h00, 5'b00100, -1);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side driver for the combinational ALU (opcodes 1..9: ADD, ADD_CARRY, SUB, INC, DEC, AND, NOT, ROL, ROR).
- Accepts commands over a valid/ready handshake and drives the ALU operand and opcode inputs.
- Captures the ALU result and flags into an accumulator and a flag register, then returns a response over a second valid/ready handshake.
- Multi-word arithmetic chains through the stored carry flag.

Parameters:
BUS_WIDTH, 8, datapath width; must match the attached ALU.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_opcode  input  4  0 = LOAD; 1..9 = ALU op; 10..15 = forwarded to ALU (invalid)
cmd_operand  input  BUS_WIDTH  B operand, or load value for LOAD
alu_opcode  output  4  to ALU opcode
alu_a  output  BUS_WIDTH  to ALU a; always the accumulator
alu_b  output  BUS_WIDTH  to ALU b; the latched operand
alu_carry_in  output  1  to ALU carry_in; the stored carry flag
alu_y  input  BUS_WIDTH  from ALU y
alu_flags  input  5  from ALU {invalid_op, parity, zero, borrow, carry_out}
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_result  output  BUS_WIDTH  result of the completed command
rsp_flags  output  5  {invalid_op, parity, zero, borrow, carry_out} of the completed command
acc  output  BUS_WIDTH  current accumulator value

Behaviour:
- Clock and reset: one clock `clk`. `reset` is asynchronous and active-high. All state is reset immediately on assertion.
- Reset values:
  - state = IDLE, cmd_ready = 1, rsp_valid = 0.
  - acc = 0, flag register = 5'b00100 (zero = 1, all others 0).
  - alu_opcode = 0, alu_b = 0, rsp_result = 0, rsp_flags = 5'b00100.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_opcode into the opcode register and cmd_operand into the operand register.
  - If opcode = 0, go to CAPT. Otherwise go to EXEC.
- EXEC (1 cycle):
  - cmd_ready = 0.
  - alu_opcode, alu_a = acc, alu_b = operand and alu_carry_in = carry flag are driven from registers and held stable for the whole cycle. This is the ALU settling cycle. Go to CAPT.
- CAPT (1 cycle):
  - ALU ops (opcode ≠ 0):
    - Sample alu_y and alu_flags into rsp_result and rsp_flags.
    - The flag register takes alu_flags.
    - acc takes alu_y only if alu_flags[4] (invalid_op) = 0; otherwise acc is unchanged.
  - LOAD:
    - acc = operand, rsp_result = operand.
    - rsp_flags = {0, ^operand, operand == 0, 0, 0}; the flag register takes the same value.
  - Go to RESP.
- RESP:
  - rsp_valid = 1 and rsp_result/rsp_flags are held stable until rsp_ready is sampled high.
  - On rsp_valid & rsp_ready, rsp_valid = 0 on the next cycle and the FSM returns to IDLE.
- Latency:
  - ALU command: accepted at edge N, rsp_valid asserts after edge N+2, i.e. visible in cycle N+3.
  - LOAD: one cycle earlier.
  - Throughput: at most one command in flight. cmd_ready = 0 in EXEC, CAPT and RESP, and returns to 1 in the cycle after the response handshake.
- Carry chaining: alu_carry_in always equals flag register bit 0 (carry_out) from the previous completed command. LOAD and invalid ops clear it to the value given above.
- alu_* outputs are registered and keep their last value outside EXEC. No combinational path from cmd_* to alu_*.
- Boundary conditions:
  - cmd_valid high while cmd_ready = 0: ignored; the command must be held by the sender.
  - rsp_ready high before rsp_valid: no effect.
  - reset asserted in any state: the in-flight command is discarded, no response is issued, and all values return to reset values immediately.
  - Opcodes 10..15: go through EXEC/CAPT, the response carries invalid_op = 1, acc is unchanged.

Test Plan:
1. Reset check: after reset -> cmd_ready = 1, rsp_valid = 0, acc = 0. Assert reset mid-EXEC -> outputs at reset values immediately, no response.
2. Load and add (BUS_WIDTH = 8): LOAD 8'hF0 -> rsp_result = F0, rsp_flags = 5'b00000. Then ADD 8'h20 -> rsp_result = 8'h10, carry = 1, acc = 8'h10.
3. Carry chain: after test 2, ADD_CARRY 8'h01 -> alu_carry_in = 1 during EXEC, rsp_result = 8'h12, carry = 0.
4. Subtract: LOAD 8'h05, then SUB 8'h05 -> result 0, zero = 1. Then DEC -> result 8'hFF, borrow = 1, parity = 0.
5. Invalid op: LOAD 8'h3C, then opcode 12 -> rsp_flags[4] = 1, rsp_result = 0, acc remains 8'h3C.
6. Response backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_result remain stable, cmd_ready = 0, and a new cmd_valid is not accepted until one cycle after the handshake.
